// File: rtl/issue_sched_if.sv
// Bundle of the fetch-side, issue-side and flow-control signals of the
// instruction queue. The scheduler attaches through the slave modport; the
// fetch/decode environment drives through the master modport.
interface issue_sched_if #(
  parameter int CNT_W = 32
);
  logic             rdy;
  logic             rollback;
  logic             if_valid;
  logic [31:0]      if_inst;
  logic [31:0]      if_pc;
  logic             if_pre_j;
  logic             if_stall;
  logic             rob_full;
  logic             rs_full;
  logic             lsb_full;
  logic             inst_done;
  logic [31:0]      inst;
  logic [31:0]      inst_pc;
  logic             inst_pre_j;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rdy, rollback, if_valid, if_inst, if_pc, if_pre_j,
    output rob_full, rs_full, lsb_full,
    input  if_stall, inst_done, inst, inst_pc, inst_pre_j, stall_cnt
  );

  modport slave (
    input  rdy, rollback, if_valid, if_inst, if_pc, if_pre_j,
    input  rob_full, rs_full, lsb_full,
    output if_stall, inst_done, inst, inst_pc, inst_pre_j, stall_cnt
  );
endinterface

// File: rtl/issue_sched.sv
// Instruction queue and issue scheduler. Fetched instructions are buffered
// in a circular FIFO; the head entry is handed to the decoder only when the
// RoB and the head's target unit (RS for ALU/branch/jump, LSB for memory
// ops) both have room. A saturating counter records structural stalls.
module issue_sched #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  issue_sched_if.slave bus
);

  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W + 1)'(DEPTH);
  localparam logic [6:0]     OP_LOAD   = 7'b0000011;
  localparam logic [6:0]     OP_STORE  = 7'b0100011;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pre_j;
  } entry_t;

  // Pointer advance; DEPTH is a power of two so the natural overflow wraps.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    else    return c + CNT_W'(1);
  endfunction

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_nxt;
  logic [CNT_W-1:0] stall_q;
  entry_t           mem [DEPTH];

  entry_t           head_ent;
  entry_t           in_ent;
  logic             full;
  logic             head_valid;
  logic             is_lsb;
  logic             target_full;
  logic             enq;
  logic             deq;
  logic             stall_evt;

  // Head decode, issue decision and queue-accept decision.
  always_comb begin
    head_ent    = mem[head_q];
    in_ent      = '{inst: bus.if_inst, pc: bus.if_pc, pre_j: bus.if_pre_j};
    full        = (count_q == FULL_CNT);
    head_valid  = (count_q != '0) && vld_q[head_q];
    is_lsb      = (head_ent.inst[6:0] == OP_LOAD) || (head_ent.inst[6:0] == OP_STORE);
    target_full = is_lsb ? bus.lsb_full : bus.rs_full;
    // Issue only from a queued entry: no fetch-to-issue bypass.
    deq         = bus.rdy && !bus.rollback && head_valid && !bus.rob_full && !target_full;
    enq         = bus.rdy && !bus.rollback && bus.if_valid && !full;
    stall_evt   = bus.rdy && !bus.rollback && head_valid && !deq;
  end

  // Next per-entry occupancy: retire the head on issue, claim the tail on accept.
  always_comb begin
    vld_nxt = vld_q;
    if (deq) vld_nxt[head_q] = 1'b0;
    if (enq) vld_nxt[tail_q] = 1'b1;
  end

  // Queue control: pointers, occupancy and flush on rollback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else if (bus.rdy) begin
      if (bus.rollback) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        vld_q   <= '0;
      end else begin
        if (enq) tail_q <= ptr_inc(tail_q);
        if (deq) head_q <= ptr_inc(head_q);
        if (enq && !deq)      count_q <= count_q + (PTR_W + 1)'(1);
        else if (!enq && deq) count_q <= count_q - (PTR_W + 1)'(1);
        vld_q <= vld_nxt;
      end
    end
  end

  // Entry payload storage; contents are qualified by vld_q/count_q, so no reset.
  always_ff @(posedge clk) begin
    if (enq) mem[tail_q] <= in_ent;
  end

  // Structural-stall counter: head present but not issued; the flush leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (stall_evt) begin
      stall_q <= sat_inc(stall_q);
    end
  end

  // Output drive: head payload is zeroed when the queue is empty.
  always_comb begin
    bus.if_stall   = full;
    bus.inst_done  = deq;
    bus.inst       = head_valid ? head_ent.inst  : 32'h0;
    bus.inst_pc    = head_valid ? head_ent.pc    : 32'h0;
    bus.inst_pre_j = head_valid ? head_ent.pre_j : 1'b0;
    bus.stall_cnt  = stall_q;
  end

endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched: a full-size instance plus a 4-bit-counter
// instance sharing the same stimulus so counter saturation is reachable.
module tb_issue_sched;

  localparam logic [31:0] I_ADD   = 32'h0000_0033;
  localparam logic [31:0] I_LOAD  = 32'h0000_2003;
  localparam logic [31:0] I_STORE = 32'h0000_2023;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  issue_sched_if #(.CNT_W(32)) bus   ();
  issue_sched_if #(.CNT_W(4))  bus_s ();

  issue_sched #(.DEPTH(8), .PTR_W(3), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  issue_sched #(.DEPTH(8), .PTR_W(3), .CNT_W(4)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s.slave)
  );

  assign bus_s.rdy      = bus.rdy;
  assign bus_s.rollback = bus.rollback;
  assign bus_s.if_valid = bus.if_valid;
  assign bus_s.if_inst  = bus.if_inst;
  assign bus_s.if_pc    = bus.if_pc;
  assign bus_s.if_pre_j = bus.if_pre_j;
  assign bus_s.rob_full = bus.rob_full;
  assign bus_s.rs_full  = bus.rs_full;
  assign bus_s.lsb_full = bus.lsb_full;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    bus.if_valid = v;
    bus.if_inst  = ins;
    bus.if_pc    = pc;
    bus.if_pre_j = pc[3];
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.rdy = 1'b1;
    bus.rollback = 1'b0;
    bus.rob_full = 1'b0;
    bus.rs_full  = 1'b0;
    bus.lsb_full = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

    // Reset state
    #2;
    chk("rst_if_stall", bus.if_stall, 0);
    chk("rst_done", bus.inst_done, 0);
    chk("rst_inst", bus.inst, 0);
    chk("rst_pc", bus.inst_pc, 0);
    chk("rst_prej", bus.inst_pre_j, 0);
    chk("rst_stall", bus.stall_cnt, 0);
    tick();
    tick();
    rst = 1'b1;

    // Three back-to-back fetches issue in order, one cycle behind
    drive(1'b1, I_ADD, 32'h0); #1;
    chk("t1_done_c1", bus.inst_done, 0);
    tick();
    drive(1'b1, I_ADD, 32'h4); #1;
    chk("t1_done_c2", bus.inst_done, 1);
    chk("t1_pc_c2", bus.inst_pc, 32'h0);
    chk("t1_inst_c2", bus.inst, I_ADD);
    tick();
    drive(1'b1, I_ADD, 32'h8); #1;
    chk("t1_done_c3", bus.inst_done, 1);
    chk("t1_pc_c3", bus.inst_pc, 32'h4);
    tick();
    drive(1'b0, 32'h0, 32'h0); #1;
    chk("t1_done_c4", bus.inst_done, 1);
    chk("t1_pc_c4", bus.inst_pc, 32'h8);
    chk("t1_prej_c4", bus.inst_pre_j, 1);
    tick(); #1;
    chk("t1_done_c5", bus.inst_done, 0);
    chk("t1_pc_empty", bus.inst_pc, 0);
    chk("t1_stall", bus.stall_cnt, 0);

    // RoB full: fill the queue, refuse a 9th fetch, then drain in order
    bus.rob_full = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, I_ADD, 32'h100 + 32'(4 * i));
      tick();
    end
    #1;
    chk("t2_if_stall_full", bus.if_stall, 1);
    chk("t2_stall7", bus.stall_cnt, 7);
    drive(1'b1, I_ADD, 32'h1F0);
    tick();
    drive(1'b0, 32'h0, 32'h0); #1;
    chk("t2_if_stall_hold", bus.if_stall, 1);
    chk("t2_stall8", bus.stall_cnt, 8);
    chk("t2_head", bus.inst_pc, 32'h100);
    bus.rob_full = 1'b0; #1;
    chk("t2_if_stall_deq", bus.if_stall, 1);
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_done", bus.inst_done, 1);
      chk("t2_drain_pc", bus.inst_pc, 32'h100 + 32'(4 * i));
      tick(); #1;
    end
    chk("t2_if_stall_clr", bus.if_stall, 0);
    chk("t2_empty_done", bus.inst_done, 0);
    chk("t2_stall_end", bus.stall_cnt, 8);
    chk("t2_stall_s", bus_s.stall_cnt, 8);

    // Target classification: load blocked by LSB, add/store routed correctly
    bus.lsb_full = 1'b1;
    drive(1'b1, I_LOAD, 32'h200); #1;
    chk("t3_done_empty", bus.inst_done, 0);
    tick();
    drive(1'b1, I_ADD, 32'h204); #1;
    chk("t3_load_head", bus.inst_pc, 32'h200);
    chk("t3_load_blocked", bus.inst_done, 0);
    tick();
    drive(1'b0, 32'h0, 32'h0); #1;
    chk("t3_load_blocked2", bus.inst_done, 0);
    tick();
    bus.lsb_full = 1'b0; #1;
    chk("t3_load_issue", bus.inst_done, 1);
    chk("t3_load_pc", bus.inst_pc, 32'h200);
    tick();
    bus.lsb_full = 1'b1; #1;
    chk("t3_add_issue", bus.inst_done, 1);
    chk("t3_add_pc", bus.inst_pc, 32'h204);
    tick();
    bus.lsb_full = 1'b0;
    bus.rs_full  = 1'b1;
    drive(1'b1, I_STORE, 32'h208);
    tick();
    drive(1'b0, 32'h0, 32'h0); #1;
    chk("t3_store_issue", bus.inst_done, 1);
    chk("t3_store_pc", bus.inst_pc, 32'h208);
    tick();
    bus.rs_full = 1'b0; #1;
    chk("t3_stall", bus.stall_cnt, 10);

    // Rollback with 5 queued entries and a fetch in flight
    bus.rob_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, I_ADD, 32'h300 + 32'(4 * i));
      tick();
    end
    bus.rollback = 1'b1;
    bus.rob_full = 1'b0;
    drive(1'b1, I_ADD, 32'h400); #1;
    chk("t4_rb_done", bus.inst_done, 0);
    chk("t4_rb_head", bus.inst_pc, 32'h300);
    tick();
    bus.rollback = 1'b0;
    drive(1'b1, I_ADD, 32'h500); #1;
    chk("t4_post_done", bus.inst_done, 0);
    chk("t4_post_empty", bus.inst_pc, 0);
    chk("t4_stall", bus.stall_cnt, 14);
    chk("t4_stall_s", bus_s.stall_cnt, 14);
    tick();
    drive(1'b0, 32'h0, 32'h0); #1;
    chk("t4_first_done", bus.inst_done, 1);
    chk("t4_first_pc", bus.inst_pc, 32'h500);
    tick(); #1;
    chk("t4_empty", bus.inst_done, 0);

    // rdy low freezes everything
    bus.rob_full = 1'b1;
    drive(1'b1, I_ADD, 32'h600);
    tick();
    drive(1'b1, I_ADD, 32'h604);
    tick();
    bus.rdy = 1'b0;
    bus.rob_full = 1'b0;
    drive(1'b1, I_ADD, 32'h700);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5_frz_done", bus.inst_done, 0);
      chk("t5_frz_pc", bus.inst_pc, 32'h600);
      chk("t5_frz_stall", bus.stall_cnt, 15);
      tick();
    end
    bus.rdy = 1'b1;
    drive(1'b0, 32'h0, 32'h0); #1;
    chk("t5_res_done0", bus.inst_done, 1);
    chk("t5_res_pc0", bus.inst_pc, 32'h600);
    tick(); #1;
    chk("t5_res_done1", bus.inst_done, 1);
    chk("t5_res_pc1", bus.inst_pc, 32'h604);
    tick(); #1;
    chk("t5_no_extra", bus.inst_done, 0);
    chk("t5_stall", bus.stall_cnt, 15);

    // 20 enqueue/dequeue pairs wrap the pointers
    drive(1'b1, I_ADD, 32'h800);
    tick();
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, I_ADD, 32'h800 + 32'(4 * i)); #1;
      chk("t6_done", bus.inst_done, 1);
      chk("t6_pc", bus.inst_pc, 32'h800 + 32'(4 * (i - 1)));
      tick();
    end
    drive(1'b0, 32'h0, 32'h0); #1;
    chk("t6_last_pc", bus.inst_pc, 32'h850);
    chk("t6_last_done", bus.inst_done, 1);
    tick(); #1;
    chk("t6_empty", bus.inst_done, 0);
    chk("t6_stall", bus.stall_cnt, 15);

    // Counter saturation on the narrow instance
    bus.rob_full = 1'b1;
    drive(1'b1, I_ADD, 32'h900);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    repeat (5) tick();
    #1;
    chk("t7_stall_wide", bus.stall_cnt, 20);
    chk("t7_stall_sat", bus_s.stall_cnt, 4'hF);
    bus.rob_full = 1'b0; #1;
    chk("t7_done", bus.inst_done, 1);
    chk("t7_pc", bus.inst_pc, 32'h900);
    tick();

    // Asynchronous reset mid-operation
    bus.rob_full = 1'b1;
    drive(1'b1, I_ADD, 32'hA00);
    tick();
    drive(1'b1, I_ADD, 32'hA04);
    tick();
    drive(1'b0, 32'h0, 32'h0); #1;
    chk("t8_pre_head", bus.inst_pc, 32'hA00);
    #1;
    rst = 1'b0; #1;
    chk("t8_rst_pc", bus.inst_pc, 0);
    chk("t8_rst_stall", bus.stall_cnt, 0);
    chk("t8_rst_if_stall", bus.if_stall, 0);
    bus.rob_full = 1'b0; #1;
    chk("t8_rst_done", bus.inst_done, 0);
    tick();
    tick();
    rst = 1'b1; #1;
    chk("t8_rel_done", bus.inst_done, 0);
    chk("t8_rel_pc", bus.inst_pc, 0);
    drive(1'b1, I_ADD, 32'hB00);
    tick();
    drive(1'b0, 32'h0, 32'h0); #1;
    chk("t8_new_done", bus.inst_done, 1);
    chk("t8_new_pc", bus.inst_pc, 32'hB00);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_sched.md
Name: issue_sched

Overview:
- Instruction queue and issue scheduler between IFetch and the decode/issue stage.
- Buffers fetched instructions in a circular FIFO and presents the head entry to the decoder only when the RoB and the target unit have room. The target unit is the RS for ALU/branch/jump ops and the LSB for loads/stores.
- Back-pressures IFetch when full and flushes on rollback.
- Keeps a saturating structural-stall counter for performance debug.

Parameters:
- DEPTH, 8, number of queue entries; power of two, minimum 2.
- PTR_W, 3, log2(DEPTH).
- CNT_W, 32, width of the stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low, all state holds.
- rollback  in  1  misprediction flush from RoB.
- if_valid  in  1  IFetch presents an instruction this cycle.
- if_inst  in  32  fetched instruction.
- if_pc  in  32  its PC.
- if_pre_j  in  1  predictor taken bit.
- if_stall  out  1  queue cannot accept; IFetch must hold.
- rob_full  in  1  RoB has no free entry.
- rs_full  in  1  RS has no free entry.
- lsb_full  in  1  LSB has no free entry.
- inst_done  out  1  head is issued to the decoder this cycle.
- inst  out  32  head instruction.
- inst_pc  out  32  head PC.
- inst_pre_j  out  1  head predictor bit.
- stall_cnt  out  CNT_W  cycles in which head was valid but blocked.

Behaviour:
- Reset (rst low, asynchronous): head=0, tail=0, count=0, stall_cnt=0, all entry valid state cleared.
  - Outputs during reset: if_stall=0, inst_done=0, inst=0, inst_pc=0, inst_pre_j=0.
- Storage: DEPTH entries of {inst, pc, pre_j}.
  - head, tail: PTR_W-bit pointers that wrap modulo DEPTH.
  - count: PTR_W+1 bits, range 0..DEPTH.
- if_stall = (count==DEPTH), combinational. Not affected by a simultaneous dequeue.
- Enqueue: at the clock edge when rdy && !rollback && if_valid && count<DEPTH.
  - Writes entry[tail]; tail+1.
  - if_valid while full is ignored; IFetch holds the instruction.
- Target classification is on head inst[6:0]:
  - 0000011 (load) or 0100011 (store) -> LSB.
  - All other opcodes -> RS.
- inst_done (combinational) = rdy && !rollback && count!=0 && !rob_full && !(target_full).
  - target_full is lsb_full for LSB ops, rs_full otherwise.
- inst, inst_pc, inst_pre_j = entry[head] whenever count!=0, else 0. They are valid regardless of inst_done.
- Dequeue: at the edge where inst_done=1; head+1.
  - Exactly one instruction issues per cycle at most.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
  - Allowed at count==DEPTH only on the dequeue side, since enqueue is refused when full.
- Latency: an instruction enqueued at edge t is at the head no earlier than the cycle after t. There is no fetch-to-issue bypass.
- Rollback (synchronous, when rdy): at the edge, head=tail=0, count=0, and the incoming if_valid is discarded.
  - inst_done=0 throughout the rollback cycle.
  - stall_cnt is unaffected by the flush.
- rdy low: no enqueue, no dequeue, no flush; inst_done=0; stall_cnt holds.
- stall_cnt increments when rdy && !rollback && count!=0 && !inst_done.
  - Saturates at all-ones; it does not wrap.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble.
- Asynchronous reset mid-operation clears the queue immediately; nothing is issued until after release.

Test Plan:
- Reset, then 3 back-to-back if_valid with all full flags low -> inst_done high in cycles 2, 3, 4 with PCs 0x0, 0x4, 0x8 in order; stall_cnt=0.
- Hold rob_full=1 and push 8 instructions -> if_stall=1 after the 8th enqueue, a 9th if_valid is not captured, stall_cnt increments each blocked cycle. Release rob_full -> issue of all 8 in order, then if_stall=0.
- Head is a load (opcode 0000011) with lsb_full=1, rs_full=0 -> inst_done=0. Head is an add (0110011) with the same flags -> inst_done=1.
- Queue holds 5 entries and rollback pulses with if_valid=1 -> inst_done=0 that cycle, count=0 next cycle, and the next issued PC is the first post-rollback fetch.
- With rdy=0 for 4 cycles while entries are queued -> no issue, pointers and stall_cnt unchanged; rdy=1 -> issue resumes at the same head.
- Run 20 enqueue/dequeue pairs with DEPTH=8 -> pointers wrap, PCs issue in order with no drop and no duplicate. Force stall_cnt near max -> it saturates at 0xFFFFFFFF.
